// File: rtl/aud_pkg.sv
// Shared types for the audio session sequencer: session states, key bundle and
// the key-priority resolver.
package aud_pkg;

  localparam int unsigned AUD_ADDR_W = 20;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_REC        = 3'd1,
    S_REC_PAUSE  = 3'd2,
    S_PLAY       = 3'd3,
    S_PLAY_PAUSE = 3'd4
  } aud_sess_e;

  typedef struct packed {
    logic play;
    logic rec;
    logic pause;
    logic stop;
  } aud_keys_t;

  // Keeps only the highest-priority key (stop > pause > rec > play).
  function automatic aud_keys_t aud_key_prio(input aud_keys_t k);
    aud_keys_t r;
    r = '0;
    if (k.stop)       r.stop  = 1'b1;
    else if (k.pause) r.pause = 1'b1;
    else if (k.rec)   r.rec   = 1'b1;
    else if (k.play)  r.play  = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/aud_sram_port_mux.sv
// Registered SRAM address / write-enable mux: the recorder owns the port while a
// recording session (active or paused) exists, the player otherwise.
module aud_sram_port_mux
  import aud_pkg::*;
#(
  parameter int unsigned ADDR_W = AUD_ADDR_W
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  aud_sess_e         i_state,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic              i_rec_wr,
  input  logic [ADDR_W-1:0] i_play_addr,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_we_n
);

  logic [ADDR_W-1:0] sram_addr_d, sram_addr_q;
  logic              sram_we_n_d, sram_we_n_q;

  always_comb begin
    sram_addr_d = i_play_addr;
    sram_we_n_d = 1'b1;
    if (i_state == S_REC || i_state == S_REC_PAUSE) begin
      sram_addr_d = i_rec_addr;
      sram_we_n_d = ~((i_state == S_REC) && i_rec_wr);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sram_addr_q <= '0;
      sram_we_n_q <= 1'b1;
    end else begin
      sram_addr_q <= sram_addr_d;
      sram_we_n_q <= sram_we_n_d;
    end
  end

  assign o_sram_addr = sram_addr_q;
  assign o_sram_we_n = sram_we_n_q;

endmodule

// File: rtl/aud_session_ctrl.sv
// Session sequencer: turns key pulses into registered start/pause/stop pulses for
// the recorder and the DSP, tracks the recorded end address and detects end of file.
module aud_session_ctrl
  import aud_pkg::*;
#(
  parameter int unsigned             ADDR_W   = AUD_ADDR_W,
  parameter logic [ADDR_W-1:0]       MAX_ADDR = {ADDR_W{1'b1}}
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_key_play,
  input  logic              i_key_rec,
  input  logic              i_key_pause,
  input  logic              i_key_stop,
  input  logic [ADDR_W-1:0] i_rec_addr,
  input  logic              i_rec_wr,
  input  logic [ADDR_W-1:0] i_play_addr,
  output logic              o_rec_start,
  output logic              o_rec_pause,
  output logic              o_rec_stop,
  output logic              o_dsp_start,
  output logic              o_dsp_pause,
  output logic              o_dsp_stop,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic              o_sram_we_n,
  output logic [ADDR_W-1:0] o_end_addr,
  output logic [2:0]        o_state
);

  aud_sess_e         state_d, state_q;
  logic [ADDR_W-1:0] end_addr_d, end_addr_q;
  logic              rec_start_d, rec_start_q;
  logic              rec_pause_d, rec_pause_q;
  logic              rec_stop_d, rec_stop_q;
  logic              dsp_start_d, dsp_start_q;
  logic              dsp_pause_d, dsp_pause_q;
  logic              dsp_stop_d, dsp_stop_q;
  aud_keys_t         key_raw, key;

  assign key_raw = '{play: i_key_play, rec: i_key_rec, pause: i_key_pause, stop: i_key_stop};
  assign key     = aud_key_prio(key_raw);

  always_comb begin
    state_d     = state_q;
    end_addr_d  = end_addr_q;
    rec_start_d = 1'b0;
    rec_pause_d = 1'b0;
    rec_stop_d  = 1'b0;
    dsp_start_d = 1'b0;
    dsp_pause_d = 1'b0;
    dsp_stop_d  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (key.rec) begin
          state_d     = S_REC;
          rec_start_d = 1'b1;
        end else if (key.play && end_addr_q != '0) begin
          state_d     = S_PLAY;
          dsp_start_d = 1'b1;
        end
      end
      S_REC: begin
        if (key.stop) begin
          state_d    = S_IDLE;
          rec_stop_d = 1'b1;
          end_addr_d = i_rec_addr;
        end else if (key.pause) begin
          state_d     = S_REC_PAUSE;
          rec_pause_d = 1'b1;
        end else if (i_rec_wr && i_rec_addr == MAX_ADDR) begin
          // Memory full: the write at MAX_ADDR still lands, then the session ends.
          state_d    = S_IDLE;
          rec_stop_d = 1'b1;
          end_addr_d = MAX_ADDR;
        end
      end
      S_REC_PAUSE: begin
        if (key.stop) begin
          state_d    = S_IDLE;
          rec_stop_d = 1'b1;
          end_addr_d = i_rec_addr;
        end else if (key.rec) begin
          state_d     = S_REC;
          rec_start_d = 1'b1;
        end
      end
      S_PLAY: begin
        if (key.stop) begin
          state_d    = S_IDLE;
          dsp_stop_d = 1'b1;
        end else if (key.pause) begin
          state_d     = S_PLAY_PAUSE;
          dsp_pause_d = 1'b1;
        end else if (i_play_addr >= end_addr_q) begin
          state_d    = S_IDLE;
          dsp_stop_d = 1'b1;
        end
      end
      S_PLAY_PAUSE: begin
        if (key.stop) begin
          state_d    = S_IDLE;
          dsp_stop_d = 1'b1;
        end else if (key.play) begin
          state_d     = S_PLAY;
          dsp_start_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      end_addr_q  <= '0;
      rec_start_q <= 1'b0;
      rec_pause_q <= 1'b0;
      rec_stop_q  <= 1'b0;
      dsp_start_q <= 1'b0;
      dsp_pause_q <= 1'b0;
      dsp_stop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      end_addr_q  <= end_addr_d;
      rec_start_q <= rec_start_d;
      rec_pause_q <= rec_pause_d;
      rec_stop_q  <= rec_stop_d;
      dsp_start_q <= dsp_start_d;
      dsp_pause_q <= dsp_pause_d;
      dsp_stop_q  <= dsp_stop_d;
    end
  end

  // Mux selects on the current state so the final auto-stop write still reaches SRAM.
  aud_sram_port_mux #(
    .ADDR_W (ADDR_W)
  ) u_sram_mux (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_state     (state_q),
    .i_rec_addr  (i_rec_addr),
    .i_rec_wr    (i_rec_wr),
    .i_play_addr (i_play_addr),
    .o_sram_addr (o_sram_addr),
    .o_sram_we_n (o_sram_we_n)
  );

  assign o_rec_start = rec_start_q;
  assign o_rec_pause = rec_pause_q;
  assign o_rec_stop  = rec_stop_q;
  assign o_dsp_start = dsp_start_q;
  assign o_dsp_pause = dsp_pause_q;
  assign o_dsp_stop  = dsp_stop_q;
  assign o_end_addr  = end_addr_q;
  assign o_state     = state_q;

endmodule

// File: tb/tb_aud_session_ctrl.sv
// Scenario bench for aud_session_ctrl: each task builds a stimulus table, pushes
// the hand-derived registered outputs for every step and compares after the edge.
module tb_aud_session_ctrl;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_REC  = 3'd1;
  localparam logic [2:0] ST_RP   = 3'd2;
  localparam logic [2:0] ST_PLAY = 3'd3;
  localparam logic [2:0] ST_PP   = 3'd4;

  localparam logic [3:0] K_NONE  = 4'b0000;
  localparam logic [3:0] K_PLAY  = 4'b1000;
  localparam logic [3:0] K_REC   = 4'b0100;
  localparam logic [3:0] K_PAUSE = 4'b0010;
  localparam logic [3:0] K_STOP  = 4'b0001;

  // {rec_start, rec_pause, rec_stop, dsp_start, dsp_pause, dsp_stop}
  localparam logic [5:0] P_NONE = 6'b000000;
  localparam logic [5:0] P_RS   = 6'b100000;
  localparam logic [5:0] P_RP   = 6'b010000;
  localparam logic [5:0] P_RT   = 6'b001000;
  localparam logic [5:0] P_DS   = 6'b000100;
  localparam logic [5:0] P_DP   = 6'b000010;
  localparam logic [5:0] P_DT   = 6'b000001;

  typedef struct packed {
    logic        rst;
    logic [3:0]  keys;
    logic        wr;
    logic [19:0] rec_addr;
    logic [19:0] play_addr;
  } stim_t;

  typedef struct packed {
    logic [2:0]  st;
    logic [5:0]  pulses;
    logic        we_n;
    logic [19:0] addr;
    logic [19:0] end_addr;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        key_play = 1'b0, key_rec = 1'b0, key_pause = 1'b0, key_stop = 1'b0;
  logic [19:0] rec_addr = '0;
  logic        rec_wr = 1'b0;
  logic [19:0] play_addr = '0;
  logic        rec_start, rec_pause, rec_stop, dsp_start, dsp_pause, dsp_stop;
  logic [19:0] sram_addr, end_addr;
  logic        sram_we_n;
  logic [2:0]  state;

  obs_t sb[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  aud_session_ctrl #(
    .ADDR_W   (20),
    .MAX_ADDR (20'hFFFFF)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_key_play  (key_play),
    .i_key_rec   (key_rec),
    .i_key_pause (key_pause),
    .i_key_stop  (key_stop),
    .i_rec_addr  (rec_addr),
    .i_rec_wr    (rec_wr),
    .i_play_addr (play_addr),
    .o_rec_start (rec_start),
    .o_rec_pause (rec_pause),
    .o_rec_stop  (rec_stop),
    .o_dsp_start (dsp_start),
    .o_dsp_pause (dsp_pause),
    .o_dsp_stop  (dsp_stop),
    .o_sram_addr (sram_addr),
    .o_sram_we_n (sram_we_n),
    .o_end_addr  (end_addr),
    .o_state     (state)
  );

  function automatic stim_t stim(input logic r, input logic [3:0] k, input logic w,
                                 input logic [19:0] ra, input logic [19:0] pa);
    stim_t s;
    s = '{rst: r, keys: k, wr: w, rec_addr: ra, play_addr: pa};
    return s;
  endfunction

  function automatic obs_t expv(input logic [2:0] st, input logic [5:0] p, input logic we_n,
                                input logic [19:0] addr, input logic [19:0] ea);
    obs_t o;
    o = '{st: st, pulses: p, we_n: we_n, addr: addr, end_addr: ea};
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o = '{st: state,
          pulses: {rec_start, rec_pause, rec_stop, dsp_start, dsp_pause, dsp_stop},
          we_n: sram_we_n, addr: sram_addr, end_addr: end_addr};
    return o;
  endfunction

  task automatic drive(input stim_t s);
    @(negedge clk);
    rst       = s.rst;
    key_play  = s.keys[3];
    key_rec   = s.keys[2];
    key_pause = s.keys[1];
    key_stop  = s.keys[0];
    rec_wr    = s.wr;
    rec_addr  = s.rec_addr;
    play_addr = s.play_addr;
  endtask

  task automatic test_reset();
    stim_t s[$];
    s.push_back(stim(1, K_REC, 1, 20'd3, 20'd4)); sb.push_back(expv(ST_IDLE, P_NONE, 1, 0, 0));
    s.push_back(stim(1, K_REC, 1, 20'd3, 20'd4)); sb.push_back(expv(ST_IDLE, P_NONE, 1, 0, 0));
    foreach (s[i]) begin
      obs_t got, want;
      drive(s[i]);
      @(posedge clk); #1;
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset[%0d]: got st=%0d p=%b we_n=%b addr=%h end=%h, exp st=%0d p=%b we_n=%b addr=%h end=%h",
                 i, got.st, got.pulses, got.we_n, got.addr, got.end_addr,
                 want.st, want.pulses, want.we_n, want.addr, want.end_addr);
      end
    end
  endtask

  task automatic test_record();
    stim_t s[$];
    s.push_back(stim(0, K_REC, 0, 0, 0)); sb.push_back(expv(ST_REC, P_RS, 1, 0, 0));
    for (int k = 0; k < 5; k++) begin
      s.push_back(stim(0, K_NONE, 1, 20'(k), 0)); sb.push_back(expv(ST_REC, P_NONE, 0, 20'(k), 0));
    end
    s.push_back(stim(0, K_STOP, 0, 20'd5, 0)); sb.push_back(expv(ST_IDLE, P_RT, 1, 20'd5, 20'd5));
    s.push_back(stim(0, K_NONE, 0, 0, 0));     sb.push_back(expv(ST_IDLE, P_NONE, 1, 0, 20'd5));
    foreach (s[i]) begin
      obs_t got, want;
      drive(s[i]);
      @(posedge clk); #1;
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL record[%0d]: got st=%0d p=%b we_n=%b addr=%h end=%h, exp st=%0d p=%b we_n=%b addr=%h end=%h",
                 i, got.st, got.pulses, got.we_n, got.addr, got.end_addr,
                 want.st, want.pulses, want.we_n, want.addr, want.end_addr);
      end
    end
  endtask

  task automatic test_playback();
    stim_t s[$];
    s.push_back(stim(0, K_PLAY, 0, 0, 0)); sb.push_back(expv(ST_PLAY, P_DS, 1, 0, 20'd5));
    for (int k = 0; k < 5; k++) begin
      s.push_back(stim(0, K_NONE, 0, 0, 20'(k))); sb.push_back(expv(ST_PLAY, P_NONE, 1, 20'(k), 20'd5));
    end
    s.push_back(stim(0, K_NONE, 0, 0, 20'd5)); sb.push_back(expv(ST_IDLE, P_DT, 1, 20'd5, 20'd5));
    s.push_back(stim(0, K_NONE, 0, 0, 0));     sb.push_back(expv(ST_IDLE, P_NONE, 1, 0, 20'd5));
    foreach (s[i]) begin
      obs_t got, want;
      drive(s[i]);
      @(posedge clk); #1;
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL playback[%0d]: got st=%0d p=%b we_n=%b addr=%h end=%h, exp st=%0d p=%b we_n=%b addr=%h end=%h",
                 i, got.st, got.pulses, got.we_n, got.addr, got.end_addr,
                 want.st, want.pulses, want.we_n, want.addr, want.end_addr);
      end
    end
  endtask

  task automatic test_play_empty();
    stim_t s[$];
    s.push_back(stim(1, K_NONE, 0, 0, 0));     sb.push_back(expv(ST_IDLE, P_NONE, 1, 0, 0));
    s.push_back(stim(0, K_PLAY, 0, 0, 20'd3)); sb.push_back(expv(ST_IDLE, P_NONE, 1, 20'd3, 0));
    s.push_back(stim(0, K_NONE, 0, 0, 0));     sb.push_back(expv(ST_IDLE, P_NONE, 1, 0, 0));
    foreach (s[i]) begin
      obs_t got, want;
      drive(s[i]);
      @(posedge clk); #1;
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL play_empty[%0d]: got st=%0d p=%b we_n=%b addr=%h end=%h, exp st=%0d p=%b we_n=%b addr=%h end=%h",
                 i, got.st, got.pulses, got.we_n, got.addr, got.end_addr,
                 want.st, want.pulses, want.we_n, want.addr, want.end_addr);
      end
    end
  endtask

  task automatic test_pause_stop();
    stim_t s[$];
    s.push_back(stim(0, K_REC,   0, 0,     0)); sb.push_back(expv(ST_REC,  P_RS,   1, 0,     0));
    s.push_back(stim(0, K_NONE,  1, 0,     0)); sb.push_back(expv(ST_REC,  P_NONE, 0, 0,     0));
    s.push_back(stim(0, K_PAUSE, 0, 20'd1, 0)); sb.push_back(expv(ST_RP,   P_RP,   1, 20'd1, 0));
    s.push_back(stim(0, K_NONE,  1, 20'd1, 0)); sb.push_back(expv(ST_RP,   P_NONE, 1, 20'd1, 0));
    s.push_back(stim(0, K_REC,   0, 20'd1, 0)); sb.push_back(expv(ST_REC,  P_RS,   1, 20'd1, 0));
    s.push_back(stim(0, K_STOP,  0, 20'd8, 0)); sb.push_back(expv(ST_IDLE, P_RT,   1, 20'd8, 20'd8));
    s.push_back(stim(0, K_PLAY,  0, 0, 0));     sb.push_back(expv(ST_PLAY, P_DS,   1, 0,     20'd8));
    s.push_back(stim(0, K_PAUSE, 0, 0, 20'd1)); sb.push_back(expv(ST_PP,   P_DP,   1, 20'd1, 20'd8));
    s.push_back(stim(0, K_NONE,  0, 0, 20'd9)); sb.push_back(expv(ST_PP,   P_NONE, 1, 20'd9, 20'd8));
    s.push_back(stim(0, K_PLAY,  0, 0, 20'd2)); sb.push_back(expv(ST_PLAY, P_DS,   1, 20'd2, 20'd8));
    s.push_back(stim(0, K_PAUSE | K_STOP, 0, 0, 20'd3)); sb.push_back(expv(ST_IDLE, P_DT, 1, 20'd3, 20'd8));
    s.push_back(stim(0, K_NONE,  0, 0, 0));     sb.push_back(expv(ST_IDLE, P_NONE, 1, 0,     20'd8));
    foreach (s[i]) begin
      obs_t got, want;
      drive(s[i]);
      @(posedge clk); #1;
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL pause_stop[%0d]: got st=%0d p=%b we_n=%b addr=%h end=%h, exp st=%0d p=%b we_n=%b addr=%h end=%h",
                 i, got.st, got.pulses, got.we_n, got.addr, got.end_addr,
                 want.st, want.pulses, want.we_n, want.addr, want.end_addr);
      end
    end
  endtask

  task automatic test_auto_stop();
    stim_t s[$];
    s.push_back(stim(0, K_REC,  0, 0,          0)); sb.push_back(expv(ST_REC,  P_NONE | P_RS, 1, 0, 20'd8));
    s.push_back(stim(0, K_NONE, 1, 20'hFFFFE, 0)); sb.push_back(expv(ST_REC,  P_NONE, 0, 20'hFFFFE, 20'd8));
    s.push_back(stim(0, K_NONE, 1, 20'hFFFFF, 0)); sb.push_back(expv(ST_IDLE, P_RT,   0, 20'hFFFFF, 20'hFFFFF));
    s.push_back(stim(0, K_NONE, 1, 20'hFFFFF, 0)); sb.push_back(expv(ST_IDLE, P_NONE, 1, 0,         20'hFFFFF));
    foreach (s[i]) begin
      obs_t got, want;
      drive(s[i]);
      @(posedge clk); #1;
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL auto_stop[%0d]: got st=%0d p=%b we_n=%b addr=%h end=%h, exp st=%0d p=%b we_n=%b addr=%h end=%h",
                 i, got.st, got.pulses, got.we_n, got.addr, got.end_addr,
                 want.st, want.pulses, want.we_n, want.addr, want.end_addr);
      end
    end
  endtask

  task automatic test_reset_mid();
    stim_t s[$];
    s.push_back(stim(0, K_REC | K_PLAY, 0, 0, 0)); sb.push_back(expv(ST_REC, P_RS, 1, 0, 20'hFFFFF));
    s.push_back(stim(0, K_NONE, 1, 20'd7, 0));     sb.push_back(expv(ST_REC, P_NONE, 0, 20'd7, 20'hFFFFF));
    s.push_back(stim(1, K_STOP, 1, 20'd8, 0));     sb.push_back(expv(ST_IDLE, P_NONE, 1, 0, 0));
    s.push_back(stim(0, K_NONE, 0, 0, 0));         sb.push_back(expv(ST_IDLE, P_NONE, 1, 0, 0));
    s.push_back(stim(0, K_PLAY, 0, 0, 0));         sb.push_back(expv(ST_IDLE, P_NONE, 1, 0, 0));
    foreach (s[i]) begin
      obs_t got, want;
      drive(s[i]);
      @(posedge clk); #1;
      got = sample(); want = sb.pop_front(); checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL reset_mid[%0d]: got st=%0d p=%b we_n=%b addr=%h end=%h, exp st=%0d p=%b we_n=%b addr=%h end=%h",
                 i, got.st, got.pulses, got.we_n, got.addr, got.end_addr,
                 want.st, want.pulses, want.we_n, want.addr, want.end_addr);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_record();
    test_playback();
    test_play_empty();
    test_pause_stop();
    test_auto_stop();
    test_reset_mid();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d leftover entries, exp 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
